// File: rtl/riscv_mem_responder_if.sv
`default_nettype none
// =====================================================================
// Interface : riscv_mem_responder_if
// Function  : core fetch/data port, host boot-load port and status
// Revision  : 1.0
// =====================================================================
interface riscv_mem_responder_if #(
   parameter int DEPTH_LOG2 = 10
);
   logic [31:0]           instr_addr;
   logic [31:0]           instr;
   logic [31:0]           data_addr;
   logic                  should_read_mem;
   logic                  should_write_mem;
   logic [31:0]           mem_write_data;
   logic [31:0]           mem_read_data;
   logic                  load_valid;
   logic                  load_ready;
   logic [DEPTH_LOG2-1:0] load_addr;
   logic [31:0]           load_data;
   logic                  load_done;
   logic                  core_run;
   logic                  fault;
   logic [1:0]            fault_cause;
   logic [31:0]           fault_addr;
   logic [31:0]           run_cycles;

   modport master (
      output instr_addr, data_addr, should_read_mem, should_write_mem, mem_write_data,
             load_valid, load_addr, load_data, load_done,
      input  instr, mem_read_data, load_ready, core_run,
             fault, fault_cause, fault_addr, run_cycles
   );

   modport slave (
      input  instr_addr, data_addr, should_read_mem, should_write_mem, mem_write_data,
             load_valid, load_addr, load_data, load_done,
      output instr, mem_read_data, load_ready, core_run,
             fault, fault_cause, fault_addr, run_cycles
   );
endinterface
`default_nettype wire

// File: rtl/riscv_mem_responder.sv
`default_nettype none
// =====================================================================
// Module   : riscv_mem_responder
// Function : unified word memory with boot-load port, sticky access
//            fault detection that halts the core, and a run counter
// Revision : 1.0
// =====================================================================
module riscv_mem_responder #(
   parameter int          DEPTH_LOG2 = 10,
   parameter bit          BOOT_LOAD  = 1'b1,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
   input  wire logic            clk,
   input  wire logic            reset,
   riscv_mem_responder_if.slave bus
);
   localparam int          c_DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [32:0] c_BYTE_LIMIT = 33'd4 << DEPTH_LOG2;

   localparam logic [1:0] c_CAUSE_NONE     = 2'd0;
   localparam logic [1:0] c_CAUSE_MISALIGN = 2'd1;
   localparam logic [1:0] c_CAUSE_RANGE    = 2'd2;
   localparam logic [1:0] c_CAUSE_CONFLICT = 2'd3;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam state_t c_RESET_STATE = BOOT_LOAD ? ST_LOAD : ST_RUN;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [31:0]           r_mem [0:c_DEPTH-1];
   logic                  r_wr_arm;
   logic                  r_fault;
   logic [1:0]            r_fault_cause;
   logic [31:0]           r_fault_addr;
   logic [31:0]           r_run_cycles;

   logic [DEPTH_LOG2-1:0] w_iidx;
   logic [DEPTH_LOG2-1:0] w_didx;
   logic                  w_i_misalign;
   logic                  w_i_range;
   logic                  w_d_access;
   logic                  w_d_misalign;
   logic                  w_d_range;
   logic                  w_conflict;
   logic                  w_fault_hit;
   logic [1:0]            w_fault_cause;
   logic [31:0]           w_fault_addr;

   logic                  w_core_run;
   logic                  w_load_ready;
   logic [31:0]           w_instr;
   logic [31:0]           w_rdata;
   logic                  w_mem_we;
   logic [DEPTH_LOG2-1:0] w_waddr;
   logic [31:0]           w_wdata;

   assign w_iidx       = bus.instr_addr[DEPTH_LOG2+1:2];
   assign w_didx       = bus.data_addr[DEPTH_LOG2+1:2];
   assign w_i_misalign = |bus.instr_addr[1:0];
   assign w_i_range    = {1'b0, bus.instr_addr} >= c_BYTE_LIMIT;
   assign w_d_access   = bus.should_read_mem | bus.should_write_mem;
   assign w_d_misalign = |bus.data_addr[1:0];
   assign w_d_range    = {1'b0, bus.data_addr} >= c_BYTE_LIMIT;
   assign w_conflict   = bus.should_read_mem & bus.should_write_mem;

   // Cause priority first, then instruction port ahead of data port.
   always_comb begin
      w_fault_hit   = 1'b0;
      w_fault_cause = c_CAUSE_NONE;
      w_fault_addr  = 32'd0;
      if (r_state == ST_RUN) begin
         if (w_conflict) begin
            w_fault_hit   = 1'b1;
            w_fault_cause = c_CAUSE_CONFLICT;
            w_fault_addr  = bus.data_addr;
         end else if (w_i_misalign) begin
            w_fault_hit   = 1'b1;
            w_fault_cause = c_CAUSE_MISALIGN;
            w_fault_addr  = bus.instr_addr;
         end else if (w_d_access && w_d_misalign) begin
            w_fault_hit   = 1'b1;
            w_fault_cause = c_CAUSE_MISALIGN;
            w_fault_addr  = bus.data_addr;
         end else if (w_i_range) begin
            w_fault_hit   = 1'b1;
            w_fault_cause = c_CAUSE_RANGE;
            w_fault_addr  = bus.instr_addr;
         end else if (w_d_access && w_d_range) begin
            w_fault_hit   = 1'b1;
            w_fault_cause = c_CAUSE_RANGE;
            w_fault_addr  = bus.data_addr;
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_core_run   = 1'b0;
      w_load_ready = 1'b0;
      w_instr      = NOP_WORD;
      w_rdata      = 32'd0;
      w_mem_we     = 1'b0;
      w_waddr      = '0;
      w_wdata      = 32'd0;
      case (r_state)
         ST_LOAD: begin
            w_load_ready = 1'b1;
            if (bus.load_valid) begin
               w_mem_we = r_wr_arm;
               w_waddr  = bus.load_addr;
               w_wdata  = bus.load_data;
            end
            if (bus.load_done) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_core_run = 1'b1;
            w_instr    = r_mem[w_iidx];
            if (bus.should_read_mem) begin
               w_rdata = r_mem[w_didx];
            end
            if (bus.should_write_mem && !w_fault_hit) begin
               w_mem_we = r_wr_arm;
               w_waddr  = w_didx;
               w_wdata  = bus.mem_write_data;
            end
            if (w_fault_hit) begin
               w_state_nxt = ST_FAULT;
            end
         end
         ST_FAULT: begin
            w_state_nxt = ST_FAULT;
         end
         default: begin
            w_state_nxt = c_RESET_STATE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_RESET_STATE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // r_wr_arm keeps any write pending across a reset assertion, and the
   // partial cycle right after release, from reaching the array.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_arm      <= 1'b0;
         r_fault       <= 1'b0;
         r_fault_cause <= c_CAUSE_NONE;
         r_fault_addr  <= 32'd0;
         r_run_cycles  <= 32'd0;
      end else begin
         r_wr_arm <= 1'b1;
         if (r_state == ST_RUN) begin
            r_run_cycles <= r_run_cycles + 32'd1;
         end
         if (w_fault_hit) begin
            r_fault       <= 1'b1;
            r_fault_cause <= w_fault_cause;
            r_fault_addr  <= w_fault_addr;
         end
      end
   end

   always_ff @(negedge clk) begin
      if (w_mem_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   assign bus.instr         = w_instr;
   assign bus.mem_read_data = w_rdata;
   assign bus.core_run      = w_core_run;
   assign bus.load_ready    = w_load_ready;
   assign bus.fault         = r_fault;
   assign bus.fault_cause   = r_fault_cause;
   assign bus.fault_addr    = r_fault_addr;
   assign bus.run_cycles    = r_run_cycles;
endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_responder.sv
`default_nettype none
// =====================================================================
// Module   : tb_riscv_mem_responder
// Function : randomized bench for riscv_mem_responder with a reference model
// Revision : 1.0
// =====================================================================
module tb_riscv_mem_responder;
   localparam int          c_DL    = 10;
   localparam int          c_WORDS = 1 << c_DL;
   localparam logic [31:0] c_NOP   = 32'h0000_0013;
   localparam int          MD_LOAD = 0;
   localparam int          MD_RUN  = 1;
   localparam int          MD_HALT = 2;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   riscv_mem_responder_if #(.DEPTH_LOG2(c_DL)) bus ();

   riscv_mem_responder #(
      .DEPTH_LOG2 (c_DL),
      .BOOT_LOAD  (1'b1),
      .NOP_WORD   (c_NOP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [31:0] m_mem [c_WORDS];
   int          m_mode;
   bit          m_armed;
   logic        m_fault;
   logic [1:0]  m_cause;
   logic [31:0] m_faddr;
   logic [31:0] m_runs;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % c_WORDS);
   endfunction

   function automatic void model_reset();
      m_mode  = MD_LOAD;
      m_armed = 1'b0;
      m_fault = 1'b0;
      m_cause = 2'd0;
      m_faddr = 32'd0;
      m_runs  = 32'd0;
   endfunction

   // Which fault (if any) the present inputs provoke while running.
   function automatic void calc_fault(output logic [1:0] c, output logic [31:0] a);
      logic        rd, wr;
      logic [31:0] ia, da;
      rd = bus.should_read_mem;
      wr = bus.should_write_mem;
      ia = bus.instr_addr;
      da = bus.data_addr;
      c  = 2'd0;
      a  = 32'd0;
      if (m_mode != MD_RUN) return;
      if (rd && wr)                                     begin c = 2'd3; a = da; end
      else if (ia % 4 != 0)                             begin c = 2'd1; a = ia; end
      else if ((rd || wr) && da % 4 != 0)               begin c = 2'd1; a = da; end
      else if (ia >= 32'(4 * c_WORDS))                  begin c = 2'd2; a = ia; end
      else if ((rd || wr) && da >= 32'(4 * c_WORDS))    begin c = 2'd2; a = da; end
   endfunction

   always @(negedge reset) model_reset();

   always @(posedge clk) begin : b_model_edge
      logic [1:0]  c;
      logic [31:0] a;
      if (reset) begin
         calc_fault(c, a);
         if (m_mode == MD_RUN) begin
            m_runs = m_runs + 32'd1;
            if (c != 2'd0) begin
               m_fault = 1'b1;
               m_cause = c;
               m_faddr = a;
               m_mode  = MD_HALT;
            end
         end else if (m_mode == MD_LOAD && bus.load_done) begin
            m_mode = MD_RUN;
         end
         m_armed = 1'b1;
      end
   end

   always @(negedge clk) begin : b_model_write
      logic [1:0]  c;
      logic [31:0] a;
      if (reset && m_armed) begin
         calc_fault(c, a);
         if (m_mode == MD_LOAD && bus.load_valid)
            m_mem[int'(bus.load_addr)] = bus.load_data;
         else if (m_mode == MD_RUN && bus.should_write_mem && c == 2'd0)
            m_mem[widx(bus.data_addr)] = bus.mem_write_data;
      end
   end

   // Every cycle, just ahead of the core's sampling edge.
   always @(negedge clk) begin : b_compare
      logic [31:0] e_instr, e_rdata;
      #3;
      e_instr = (m_mode == MD_RUN) ? m_mem[widx(bus.instr_addr)] : c_NOP;
      e_rdata = (m_mode == MD_RUN && bus.should_read_mem) ? m_mem[widx(bus.data_addr)] : 32'd0;
      chk("instr",       bus.instr,         e_instr);
      chk("rdata",       bus.mem_read_data, e_rdata);
      chk("core_run",    32'(bus.core_run),    32'(m_mode == MD_RUN));
      chk("load_ready",  32'(bus.load_ready),  32'(m_mode == MD_LOAD));
      chk("fault",       32'(bus.fault),       32'(m_fault));
      chk("fault_cause", 32'(bus.fault_cause), 32'(m_cause));
      chk("fault_addr",  bus.fault_addr,  m_faddr);
      chk("run_cycles",  bus.run_cycles,  m_runs);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.instr_addr       = 32'd0;
      bus.data_addr        = 32'd0;
      bus.should_read_mem  = 1'b0;
      bus.should_write_mem = 1'b0;
      bus.mem_write_data   = 32'd0;
      bus.load_valid       = 1'b0;
      bus.load_addr        = '0;
      bus.load_data        = 32'd0;
      bus.load_done        = 1'b0;
   endtask

   task automatic reset_and_reload(input int nbeats);
      idle_inputs();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      for (int b = 0; b < nbeats; b++) begin
         int ad;
         ad = 2 + b;
         bus.load_valid = 1'b1;
         bus.load_addr  = ad[c_DL-1:0];
         bus.load_data  = $urandom;
         step();
      end
      idle_inputs();
      bus.load_done = 1'b1;
      step();
      bus.load_done = 1'b0;
   endtask

   task automatic rand_traffic(input bit allow_fault);
      int          op;
      logic [31:0] ia, da;
      op = $urandom_range(0, 3);
      ia = 32'($urandom_range(0, c_WORDS - 1)) << 2;
      da = 32'($urandom_range(2, c_WORDS - 1)) << 2;
      if (op == 3) ia = da;
      if (op == 0) da = $urandom;
      bus.should_read_mem  = (op == 1);
      bus.should_write_mem = (op >= 2);
      if (allow_fault) begin
         if ($urandom_range(0, 29) == 0) ia = ia | 32'($urandom_range(1, 3));
         if ($urandom_range(0, 29) == 0) ia = ia | (32'h1000 << $urandom_range(0, 19));
         if ($urandom_range(0, 29) == 0) da = da | 32'($urandom_range(1, 3));
         if ($urandom_range(0, 29) == 0) da = da | (32'h1000 << $urandom_range(0, 19));
         if ($urandom_range(0, 29) == 0) begin
            bus.should_read_mem  = 1'b1;
            bus.should_write_mem = 1'b1;
         end
      end
      bus.instr_addr     = ia;
      bus.data_addr      = da;
      bus.mem_write_data = $urandom;
      bus.load_valid     = 1'($urandom_range(0, 1));
      bus.load_addr      = c_DL'($urandom);
      bus.load_data      = $urandom;
      bus.load_done      = 1'($urandom_range(0, 1));
   endtask

   initial begin : b_stim
      int          rc;
      logic [31:0] old_w;
      idle_inputs();
      model_reset();
      repeat (3) step();
      bus.instr_addr = 32'h0000_0123;
      #1;
      chk("boot_load_ready", 32'(bus.load_ready), 32'd1);
      chk("boot_core_run",   32'(bus.core_run),   32'd0);
      chk("boot_instr_nop",  bus.instr,           32'h0000_0013);
      chk("boot_run_cycles", bus.run_cycles,      32'd0);
      chk("boot_fault",      32'(bus.fault),      32'd0);
      reset = 1'b1;
      step();
      step();

      // Fill the whole array; the last beat coincides with load_done.
      for (int a = 0; a < c_WORDS; a++) begin
         while ($urandom_range(0, 3) == 0) begin
            bus.load_valid       = 1'b0;
            bus.load_addr        = c_DL'($urandom);
            bus.load_data        = $urandom;
            bus.should_write_mem = 1'b1;
            bus.data_addr        = 32'($urandom_range(0, c_WORDS - 1)) << 2;
            step();
         end
         bus.load_valid       = 1'b1;
         bus.load_addr        = a[c_DL-1:0];
         bus.load_data        = (a == 0) ? 32'h0050_0093 : (a == 1) ? 32'h00A0_0113 : $urandom;
         bus.should_read_mem  = 1'($urandom_range(0, 1));
         bus.should_write_mem = 1'($urandom_range(0, 1));
         bus.data_addr        = 32'($urandom_range(0, c_WORDS - 1)) << 2;
         bus.mem_write_data   = $urandom;
         bus.load_done        = (a == c_WORDS - 1);
         step();
      end
      idle_inputs();
      chk("run_after_done", 32'(bus.core_run),   32'd1);
      chk("ready_after_done", 32'(bus.load_ready), 32'd0);
      chk("run_cycles_start", bus.run_cycles,    32'd0);
      bus.instr_addr = 32'd4;
      #1;
      chk("fetch_word1", bus.instr, 32'h00A0_0113);
      bus.instr_addr = 32'd0;
      #1;
      chk("fetch_word0", bus.instr, 32'h0050_0093);
      rc = 0;
      for (int k = 1; k <= 3; k++) begin
         step();
         rc++;
         chk("run_cycles_count", bus.run_cycles, 32'(k));
      end

      bus.should_write_mem = 1'b1;
      bus.data_addr        = 32'h40;
      bus.mem_write_data   = 32'hDEAD_BEEF;
      step();
      rc++;
      bus.should_write_mem = 1'b0;
      bus.should_read_mem  = 1'b1;
      #1;
      chk("store_load_0x40", bus.mem_read_data, 32'hDEAD_BEEF);
      step();
      rc++;

      // Fetch and store to the same word in one cycle.
      bus.should_read_mem  = 1'b0;
      bus.instr_addr       = 32'h200;
      bus.should_write_mem = 1'b1;
      bus.data_addr        = 32'h200;
      bus.mem_write_data   = 32'h0BAD_F00D;
      #1;
      chk("same_cycle_old", bus.instr, m_mem[128]);
      @(negedge clk);
      #1;
      chk("same_cycle_new", bus.instr, 32'h0BAD_F00D);
      step();
      rc++;

      repeat (1500) begin
         rand_traffic(1'b0);
         step();
         rc++;
      end

      idle_inputs();
      bus.should_read_mem = 1'b1;
      bus.data_addr       = 32'h42;
      step();
      rc++;
      chk("misalign_fault",  32'(bus.fault),       32'd1);
      chk("misalign_cause",  32'(bus.fault_cause), 32'd1);
      chk("misalign_addr",   bus.fault_addr,       32'h42);
      chk("misalign_halt",   32'(bus.core_run),    32'd0);
      chk("misalign_nop",    bus.instr,            c_NOP);
      chk("misalign_rc",     bus.run_cycles,       32'(rc));
      repeat (4) step();
      chk("frozen_rc",       bus.run_cycles,       32'(rc));
      chk("sticky_fault",    32'(bus.fault),       32'd1);

      reset_and_reload(4);
      bus.should_write_mem = 1'b1;
      bus.data_addr        = 32'h1000;
      bus.mem_write_data   = 32'h1234_5678;
      step();
      chk("range_cause", 32'(bus.fault_cause), 32'd2);
      chk("range_addr",  bus.fault_addr,       32'h1000);
      reset_and_reload(0);
      bus.should_read_mem = 1'b1;
      bus.data_addr       = 32'd0;
      #1;
      chk("word0_unaliased", bus.mem_read_data, 32'h0050_0093);
      step();

      idle_inputs();
      old_w                = m_mem[32];
      bus.should_read_mem  = 1'b1;
      bus.should_write_mem = 1'b1;
      bus.data_addr        = 32'h80;
      bus.mem_write_data   = 32'hFFFF_0000;
      step();
      chk("conflict_cause", 32'(bus.fault_cause), 32'd3);
      chk("conflict_addr",  bus.fault_addr,       32'h80);
      #1;
      reset = 1'b0;
      #1;
      chk("async_clr_fault", 32'(bus.fault),      32'd0);
      chk("async_load",      32'(bus.load_ready), 32'd1);
      reset_and_reload(0);
      bus.should_read_mem = 1'b1;
      bus.data_addr       = 32'h80;
      #1;
      chk("conflict_no_write", bus.mem_read_data, old_w);
      step();

      // Reset lands between a store request and its negedge.
      idle_inputs();
      old_w                = m_mem[64];
      bus.should_write_mem = 1'b1;
      bus.data_addr        = 32'h100;
      bus.mem_write_data   = 32'hCAFE_F00D;
      #1;
      reset = 1'b0;
      @(negedge clk);
      #1;
      reset_and_reload(0);
      bus.should_read_mem = 1'b1;
      bus.data_addr       = 32'h100;
      #1;
      chk("reset_drops_write", bus.mem_read_data, old_w);
      step();

      repeat (25) begin
         reset_and_reload($urandom_range(0, 4));
         repeat ($urandom_range(5, 40)) begin
            rand_traffic(1'b1);
            step();
         end
      end
      idle_inputs();
      step();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/riscv_mem_responder.md
Name: riscv_mem_responder

Overview:
- Unified word-addressed memory that sits on the far side of the core's memory interface.
- Serves the instruction-fetch port (instr_addr -> instr) and the data port (data_addr, should_read_mem, should_write_mem, mem_write_data -> mem_read_data).
- Adds a boot-load port so a host can stream a program into memory while the core is held.
- Detects misaligned, out-of-range and conflicting accesses; on detection it latches a sticky fault and halts the core.

Parameters:
DEPTH_LOG2, 10, memory depth is 2^DEPTH_LOG2 32-bit words
BOOT_LOAD, 1, 1: reset enters LOAD; 0: reset enters RUN directly
NOP_WORD, 32'h00000013, instruction returned whenever state is not RUN

Ports:
clk  input  1  single clock
reset  input  1  asynchronous, active-low reset (low = in reset)
instr_addr  input  32  byte address of instruction fetch
instr  output  32  fetched instruction word
data_addr  input  32  byte address of data access
should_read_mem  input  1  data read request
should_write_mem  input  1  data write request
mem_write_data  input  32  store data
mem_read_data  output  32  load data
load_valid  input  1  host load beat valid
load_ready  output  1  responder accepts load beats
load_addr  input  DEPTH_LOG2  word index of load beat
load_data  input  32  load beat data
load_done  input  1  host signals end of program load
core_run  output  1  1 = core may execute (top gates core reset/enable with this)
fault  output  1  sticky fault flag
fault_cause  output  2  0 none, 1 misaligned, 2 out of range, 3 read+write conflict
fault_addr  output  32  byte address that caused the fault
run_cycles  output  32  count of clk cycles spent in RUN

Behaviour:
- States: LOAD, RUN, FAULT. State register updates on posedge clk; reset low forces the state asynchronously to LOAD if BOOT_LOAD = 1, else RUN.
- Reset values: core_run = (BOOT_LOAD == 0), load_ready = (BOOT_LOAD == 1), fault = 0, fault_cause = 0, fault_addr = 0, run_cycles = 0. Memory contents are not reset.
- Reads are asynchronous from the array:
  - In RUN: instr = mem[instr_addr[DEPTH_LOG2+1:2]]; mem_read_data = mem[data_addr[...]] when should_read_mem, else 0.
  - In LOAD or FAULT: instr = NOP_WORD and mem_read_data = 0.
- All array writes commit on negedge clk, using the request signals as sampled at that negedge.
- LOAD state:
  - load_ready = 1 and core_run = 0.
  - A beat is accepted when load_valid & load_ready at negedge; it writes load_data to mem[load_addr].
  - Core data-port writes are ignored.
  - load_done high at posedge -> RUN. A beat present in the same cycle as load_done is still written, at the preceding negedge.
  - No load_addr range check is needed; the width is exact.
- RUN state:
  - core_run = 1 and load_ready = 0.
  - run_cycles increments by 1 every posedge while in RUN and wraps from 2^32-1 to 0.
  - A data write occurs at negedge when should_write_mem and no fault condition is present in that cycle.
- Fault conditions, evaluated combinationally in RUN. Priority when several hold: conflict > misaligned > out of range; instr port is checked before the data port.
  - Instruction fetch: instr_addr[1:0] != 0 gives cause 1; instr_addr >= 4*2^DEPTH_LOG2 gives cause 2.
  - Data access with should_read_mem or should_write_mem: same checks on data_addr.
  - should_read_mem & should_write_mem together gives cause 3, with fault_addr = data_addr.
- On a fault condition:
  - The faulting write is suppressed.
  - At the next posedge: state -> FAULT; fault, fault_cause and fault_addr are latched; run_cycles freezes.
- FAULT state:
  - core_run = 0, load_ready = 0, no writes.
  - The state is left only by reset.
- Reset asserted mid-write: any write whose negedge has not yet occurred is dropped. Asynchronous reset also clears the negedge-side write-enable qualification.
- Same-cycle read and write to the same address: the read returns the old word until the negedge, then the new word. The core sampling at the next posedge sees the new word.

Test Plan:
- Reset low then high with BOOT_LOAD=1 -> load_ready=1, core_run=0, instr=0x00000013 for any instr_addr, run_cycles=0.
- Load beats (addr 0, 0x00500093), (addr 1, 0x00A00113), then load_done -> core_run=1 next posedge; instr_addr=4 returns 0x00A00113; run_cycles counts 1,2,3...
- RUN: should_write_mem with data_addr=0x40, data 0xDEADBEEF; next cycle should_read_mem at 0x40 -> mem_read_data=0xDEADBEEF.
- RUN: should_read_mem with data_addr=0x42 -> fault=1, fault_cause=1, fault_addr=0x42, core_run=0, instr=NOP_WORD; run_cycles frozen.
- RUN, DEPTH_LOG2=10: should_write_mem at 0x1000 -> fault_cause=2; a read-back after reset+reload shows address 0x1000 aliased nowhere and word 0 unchanged.
- RUN: should_read_mem & should_write_mem both high at 0x80 -> fault_cause=3 and the write is suppressed; reset low mid-cycle -> state LOAD, fault=0 immediately.
